// File: rtl/rtc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rtc_pkg : constants, mode codes, FSM states and RTC address map shared by  |
// |           rtc_read_sequencer (optional feature macro: RTC_ACK_TIMEOUT_EN)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rtc_pkg;

  localparam int RTC_DATA_W   = 8;
  localparam int RTC_NUM_REGS = 10;
  localparam int RTC_IDX_W    = 4;

  localparam logic [2:0] MODE_NORMAL = 3'b000;
  localparam logic [2:0] MODE_HORA   = 3'b001;
  localparam logic [2:0] MODE_FECHA  = 3'b010;
  localparam logic [2:0] MODE_TIMER  = 3'b100;

  localparam int HORA_FIRST  = 0;
  localparam int HORA_LAST   = 2;
  localparam int FECHA_FIRST = 3;
  localparam int FECHA_LAST  = 6;
  localparam int TIMER_FIRST = 7;
  localparam int TIMER_LAST  = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_REQ     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

  function automatic logic [7:0] rtc_addr(input logic [RTC_IDX_W-1:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h27;
      4'd7:    a = 8'h41;
      4'd8:    a = 8'h42;
      4'd9:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Unknown configuration codes mask everything so no register can be clobbered.
  function automatic logic idx_masked(input logic [2:0] mode, input logic [RTC_IDX_W-1:0] idx);
    int  i;
    logic m;
    i = int'(idx);
    case (mode)
      MODE_NORMAL: m = 1'b0;
      MODE_HORA:   m = (i >= HORA_FIRST)  && (i <= HORA_LAST);
      MODE_FECHA:  m = (i >= FECHA_FIRST) && (i <= FECHA_LAST);
      MODE_TIMER:  m = (i >= TIMER_FIRST) && (i <= TIMER_LAST);
      default:     m = 1'b1;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_read_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rtc_read_sequencer_if : req/ack read bus between sequencer and RTC ctrl    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface rtc_read_sequencer_if #(
  parameter int DATA_W = rtc_pkg::RTC_DATA_W
);
  logic              bus_req;
  logic [7:0]        bus_addr;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_data_in;

  modport master (output bus_req, bus_addr, input bus_ack, bus_data_in);
  modport slave  (input bus_req, bus_addr, output bus_ack, bus_data_in);
endinterface
`default_nettype wire

// File: rtl/rtc_next_index.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rtc_next_index : lowest index >= idx not owned by the group being edited   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rtc_next_index
  import rtc_pkg::*;
#(
  parameter int NUM_REGS = RTC_NUM_REGS
) (
  input  logic [2:0]           mode,
  input  logic [RTC_IDX_W-1:0] idx,
  output logic [RTC_IDX_W-1:0] next_idx,
  output logic                 none
);

  // Scanning downward leaves the lowest qualifying index as the final winner.
  always_comb begin
    next_idx = idx;
    none     = 1'b1;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if ((RTC_IDX_W'(i) >= idx) && !idx_masked(mode, RTC_IDX_W'(i))) begin
        next_idx = RTC_IDX_W'(i);
        none     = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rtc_read_sequencer : periodic RTC register read sweep with config masking  |
// | Optional: `define RTC_ACK_TIMEOUT_EN for ack timeout / timeout_err         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter int DATA_W         = RTC_DATA_W,
  parameter int NUM_REGS       = RTC_NUM_REGS,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_sweep,
  input  logic [2:0]           funcion_conf,
  rtc_read_sequencer_if.master bus,
  output logic [3:0]           addr_mem_local,
  output logic                 reg_rd,
  output logic [DATA_W-1:0]    dato_reg,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 timeout_err
);

  localparam logic [RTC_IDX_W-1:0] LAST_IDX = RTC_IDX_W'(NUM_REGS - 1);

  seq_state_t           state_q, state_d;
  logic [RTC_IDX_W-1:0] idx_q, idx_d;
  logic [2:0]           mode_q;
  logic [7:0]           bus_addr_q;
  logic [3:0]           addr_mem_q;
  logic [DATA_W-1:0]    dato_q;
  logic [RTC_IDX_W-1:0] sel_idx;
  logic                 sel_none;
  logic                 ack_take;
  logic                 tmo_expire;

  rtc_next_index #(
    .NUM_REGS (NUM_REGS)
  ) u_next_index (
    .mode     (mode_q),
    .idx      (idx_q),
    .next_idx (sel_idx),
    .none     (sel_none)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ack_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_sweep) begin
          state_d = ST_SELECT;
          idx_d   = '0;
        end
      end
      ST_SELECT: begin
        if (sel_none) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
          idx_d   = sel_idx;
        end
      end
      ST_REQ: begin
        if (bus.bus_ack) begin
          ack_take = 1'b1;
          state_d  = ST_CAPTURE;
        end else if (tmo_expire) begin
          state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_SELECT;
          idx_d   = idx_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_SELECT;
        idx_d   = idx_q + 4'd1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mode_q     <= MODE_NORMAL;
      bus_addr_q <= '0;
      addr_mem_q <= '0;
      dato_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if ((state_q == ST_IDLE) && start_sweep)
        mode_q <= funcion_conf;
      // Address is registered one cycle ahead so it is stable for the whole REQ phase.
      if ((state_q == ST_SELECT) && !sel_none)
        bus_addr_q <= rtc_addr(sel_idx);
      if (ack_take) begin
        dato_q     <= bus.bus_data_in;
        addr_mem_q <= idx_q;
      end
    end
  end

`ifdef RTC_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_err_q;

  assign tmo_expire = (state_q == ST_REQ) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || (state_q != ST_REQ))
      tmo_cnt <= '0;
    else if (!bus.bus_ack)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      timeout_err_q <= 1'b0;
    else if ((state_q == ST_IDLE) && start_sweep)
      timeout_err_q <= 1'b0;
    else if ((state_q == ST_REQ) && !bus.bus_ack && tmo_expire)
      timeout_err_q <= 1'b1;
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_expire         = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  assign bus.bus_req    = (state_q == ST_REQ);
  assign bus.bus_addr   = bus_addr_q;
  assign addr_mem_local = addr_mem_q;
  assign dato_reg       = dato_q;
  assign reg_rd         = (state_q != ST_CAPTURE);
  assign busy           = (state_q != ST_IDLE);
  assign sweep_done     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_rtc_read_sequencer : randomized sweeps against a read-list model        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rtc_read_sequencer;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 10;
  localparam int TMO      = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_sweep;
  logic [2:0]        funcion_conf;
  logic [3:0]        addr_mem_local;
  logic              reg_rd;
  logic [DATA_W-1:0] dato_reg;
  logic              busy;
  logic              sweep_done;
  logic              timeout_err;

  rtc_read_sequencer_if #(.DATA_W(DATA_W)) bus ();

  rtc_read_sequencer #(
    .DATA_W         (DATA_W),
    .NUM_REGS       (NUM_REGS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_sweep    (start_sweep),
    .funcion_conf   (funcion_conf),
    .bus            (bus),
    .addr_mem_local (addr_mem_local),
    .reg_rd         (reg_rd),
    .dato_reg       (dato_reg),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int ref_addr [NUM_REGS] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int lat_fixed   = 1;
  int no_ack_addr = -1;
  bit data_mode   = 1'b0;
  bit junk_acks   = 1'b1;

  int rd_idx[$];
  int rd_data[$];
  int ack_addr[$];
  int sent_data[$];
  int done_cnt     = 0;
  int done_cyc     = 0;
  int req23_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit tb_masked(input int mode, input int i);
    case (mode)
      0:       return 1'b0;
      1:       return i <= 2;
      2:       return (i >= 3) && (i <= 6);
      4:       return i >= 7;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int idx_of(input int addr);
    for (int i = 0; i < NUM_REGS; i++)
      if (ref_addr[i] == addr) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!reg_rd) begin
      rd_idx.push_back(int'(addr_mem_local));
      rd_data.push_back(int'(dato_reg));
    end
    if (bus.bus_req && bus.bus_ack) ack_addr.push_back(int'(bus.bus_addr));
    if (bus.bus_req && (bus.bus_addr == 8'h23)) req23_cycles++;
    if (sweep_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // RTC bus responder: programmable ack latency, optional dead address, stray acks while idle.
  initial begin
    int wait_cnt;
    int cur_lat;
    int d;
    wait_cnt = 0;
    cur_lat  = 1;
    bus.bus_ack     = 1'b0;
    bus.bus_data_in = '0;
    forever begin
      @(posedge clk); #1;
      bus.bus_ack = 1'b0;
      if (bus.bus_req) begin
        if ((no_ack_addr >= 0) && (int'(bus.bus_addr) == no_ack_addr)) begin
          wait_cnt = 0;
        end else if (wait_cnt >= cur_lat) begin
          d = data_mode ? idx_of(int'(bus.bus_addr)) + 16 : int'($urandom_range(0, 255));
          bus.bus_ack     = 1'b1;
          bus.bus_data_in = DATA_W'(d);
          sent_data.push_back(d);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        cur_lat  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        if (junk_acks && ($urandom_range(0, 3) == 0)) begin
          bus.bus_ack     = 1'b1;
          bus.bus_data_in = DATA_W'($urandom_range(0, 255));
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_bus_req"},     bus.bus_req,    1'b0);
    check({tag, "_bus_addr"},    bus.bus_addr,   8'h00);
    check({tag, "_addr_mem"},    addr_mem_local, 4'h0);
    check({tag, "_reg_rd"},      reg_rd,         1'b1);
    check({tag, "_dato_reg"},    dato_reg,       8'h00);
    check({tag, "_busy"},        busy,           1'b0);
    check({tag, "_sweep_done"},  sweep_done,     1'b0);
    check({tag, "_timeout_err"}, timeout_err,    1'b0);
  endtask

  task automatic run_sweep(input logic [2:0] mode, input logic [2:0] mid_mode, input bit restart_mid,
                           input int exp_lat, input int skip_idx, input bit exp_terr);
    int exp_idx[$];
    int start_cyc;
    int n;
    int exp_d;
    for (int i = 0; i < NUM_REGS; i++)
      if (!tb_masked(int'(mode), i) && (i != skip_idx)) exp_idx.push_back(i);
    rd_idx.delete();
    rd_data.delete();
    ack_addr.delete();
    sent_data.delete();
    done_cnt     = 0;
    req23_cycles = 0;

    @(posedge clk); #1;
    start_sweep  = 1'b1;
    funcion_conf = mode;
    start_cyc    = cyc;
    @(posedge clk); #1;
    start_sweep  = 1'b0;
    funcion_conf = mid_mode;
    check("busy_after_start", busy, 1'b1);

    n = 0;
    while ((done_cnt == 0) && (n < 2000)) begin
      @(posedge clk); #1;
      n++;
      start_sweep = restart_mid && (n == 1);
    end
    start_sweep = 1'b0;
    check("sweep_done_seen", done_cnt, 1);
    if (exp_lat >= 0) check("done_latency", done_cyc - start_cyc, exp_lat);

    repeat (12) @(posedge clk);
    #1;
    check("single_sweep", done_cnt, 1);
    check("idle_after", busy, 1'b0);
    check("timeout_err", timeout_err, exp_terr);
    check("n_reads", rd_idx.size(), exp_idx.size());
    check("n_acks", ack_addr.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size(); i++) begin
      if (i < rd_idx.size()) begin
        exp_d = data_mode ? exp_idx[i] + 16 : ((i < sent_data.size()) ? sent_data[i] : -1);
        check("rd_index", rd_idx[i], exp_idx[i]);
        check("rd_data", rd_data[i], exp_d);
      end
      if (i < ack_addr.size()) check("bus_addr", ack_addr[i], ref_addr[exp_idx[i]]);
    end
  endtask

  task automatic reset_mid_sweep();
    int n;
    int r0;
    lat_fixed = 3;
    rd_idx.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start_sweep  = 1'b1;
    funcion_conf = 3'b000;
    @(posedge clk); #1;
    start_sweep = 1'b0;
    n = 0;
    while (!(bus.bus_req && (bus.bus_addr == 8'h25)) && (n < 500)) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_idx4", n < 500, 1'b1);
    reset = 1'b1;
    r0 = rd_idx.size();
    @(posedge clk); #1;
    check_reset_vals("mid_reset");
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_rd_after_reset", rd_idx.size(), r0);
    check("no_done_after_reset", done_cnt, 0);
    check("no_req_after_reset", bus.bus_req, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [2:0] m, mm;
    reset        = 1'b1;
    start_sweep  = 1'b0;
    funcion_conf = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    lat_fixed = 1;
    run_sweep(3'b000, 3'b000, 1'b0, 41, -1, 1'b0);

    data_mode = 1'b1;
    run_sweep(3'b001, 3'b001, 1'b0, -1, -1, 1'b0);
    data_mode = 1'b0;

    lat_fixed = -1;
    run_sweep(3'b010, 3'b100, 1'b0, -1, -1, 1'b0);
    run_sweep(3'b011, 3'b000, 1'b1, 2, -1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 4))
        0:       m = 3'b000;
        1:       m = 3'b001;
        2:       m = 3'b010;
        3:       m = 3'b100;
        default: m = 3'($urandom_range(0, 7));
      endcase
      mm = 3'($urandom_range(0, 7));
      run_sweep(m, mm, 1'($urandom_range(0, 1)), -1, -1, 1'b0);
    end

    reset_mid_sweep();

`ifdef RTC_ACK_TIMEOUT_EN
    lat_fixed   = 1;
    no_ack_addr = 8'h23;
    run_sweep(3'b000, 3'b000, 1'b0, -1, 2, 1'b1);
    check("req_len_idx2", req23_cycles, TMO);
    no_ack_addr = -1;
    run_sweep(3'b011, 3'b000, 1'b0, 2, -1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
